// File: rtl/sprite_line_scanout.sv
// Ping-pong sprite line buffer: the engine fills the draw bank while the display bank is streamed
// out against hcount and cleared behind the read. The banks swap at end of line.
module sprite_line_scanout #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter logic [15:0] TRANSPARENT = 16'h0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [9:0]  hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic [9:0]  sprite_pixel_col_i,
    input  logic [15:0] sprite_pixel_data_i,
    input  logic        wren_pixel_draw_i,
    input  logic        sprite_done_i,
    output logic        sprite_start_o,
    output logic [15:0] pix_data_o,
    output logic        pix_opaque_o,
    output logic        init_busy_o,
    output logic [7:0]  overrun_cnt_o
);

    localparam logic [9:0] HActiveW = 10'(H_ACTIVE);
    localparam logic [9:0] HLastW   = 10'(H_TOTAL - 1);

    typedef enum logic {StInit, StRun} state_e;

    state_e      state_q;
    logic        bank_sel_q;
    logic        first_swap_q;
    logic [9:0]  clr_addr_q;
    logic        sprite_start_q;
    logic [15:0] pix_data_q;
    logic        pix_opaque_q;
    logic        init_busy_q;
    logic [7:0]  overrun_cnt_q;

    logic [15:0] mem_q [2][H_ACTIVE];

    logic        we    [2];
    logic [9:0]  waddr [2];
    logic [15:0] wdata [2];
    logic        scan_hit;
    logic        draw_hit;

    // vcount is carried for debug visibility only
    logic unused_vcount;
    assign unused_vcount = ^vcount_i;

    assign scan_hit = (state_q == StRun) && (hcount_i < HActiveW);
    assign draw_hit = (state_q == StRun) && wren_pixel_draw_i &&
                      (sprite_pixel_col_i < HActiveW) && (sprite_pixel_data_i != TRANSPARENT);

    // Each bank has exactly one writer: the init clear, the scanout clear or the engine.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            we[b]    = 1'b0;
            waddr[b] = '0;
            wdata[b] = TRANSPARENT;
        end
        if (state_q == StInit) begin
            for (int b = 0; b < 2; b++) begin
                we[b]    = 1'b1;
                waddr[b] = clr_addr_q;
            end
        end else begin
            we[bank_sel_q]     = scan_hit;
            waddr[bank_sel_q]  = hcount_i;
            we[~bank_sel_q]    = draw_hit;
            waddr[~bank_sel_q] = sprite_pixel_col_i;
            wdata[~bank_sel_q] = sprite_pixel_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 2; b++) begin
            if (we[b]) begin
                mem_q[b][waddr[b]] <= wdata[b];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= StInit;
            bank_sel_q     <= 1'b0;
            first_swap_q   <= 1'b0;
            clr_addr_q     <= '0;
            sprite_start_q <= 1'b0;
            pix_data_q     <= '0;
            pix_opaque_q   <= 1'b0;
            init_busy_q    <= 1'b1;
            overrun_cnt_q  <= '0;
        end else begin
            sprite_start_q <= 1'b0;
            pix_data_q     <= '0;
            pix_opaque_q   <= 1'b0;
            unique case (state_q)
                StInit: begin
                    clr_addr_q <= clr_addr_q + 10'd1;
                    if (clr_addr_q == HActiveW - 10'd1) begin
                        state_q      <= StRun;
                        init_busy_q  <= 1'b0;
                        first_swap_q <= 1'b1;
                        clr_addr_q   <= '0;
                    end
                end
                StRun: begin
                    // Read returns pre-clear contents; the clear lands on the same edge.
                    if (scan_hit) begin
                        pix_data_q   <= mem_q[bank_sel_q][hcount_i];
                        pix_opaque_q <= (mem_q[bank_sel_q][hcount_i] != TRANSPARENT);
                    end
                    if (hcount_i == HLastW) begin
                        bank_sel_q     <= ~bank_sel_q;
                        sprite_start_q <= 1'b1;
                        first_swap_q   <= 1'b0;
                        if (!first_swap_q && !sprite_done_i && (overrun_cnt_q != 8'hFF)) begin
                            overrun_cnt_q <= overrun_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign sprite_start_o = sprite_start_q;
    assign pix_data_o     = pix_data_q;
    assign pix_opaque_o   = pix_opaque_q;
    assign init_busy_o    = init_busy_q;
    assign overrun_cnt_o  = overrun_cnt_q;

endmodule

// File: doc/sprite_line_scanout.md
Name: sprite_line_scanout

Overview:
- Consumer end of the sprite engine's pixel-draw interface.
- Holds a ping-pong pair of H_ACTIVE x 16-bit line buffers. The sprite engine writes line N+1 into the draw bank while the display bank for line N is streamed out against the VGA hcount.
- Each displayed entry is cleared after it is read. Banks swap at end of line, and the block pulses sprite_start to kick the engine for the next line.
- Sits between sprite_engine and the pixel compositor/VGA output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line; buffer depth.
- H_TOTAL, 800, hcount period (last value H_TOTAL-1).
- TRANSPARENT, 16'h0000, colour key meaning "no sprite pixel".

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- hcount  input  10  VGA horizontal counter, 0..H_TOTAL-1
- vcount  input  10  VGA vertical counter (informational; passed through for debug only)
- sprite_pixel_col  input  10  draw-bank write column from sprite engine
- sprite_pixel_data  input  16  RGB565 pixel from sprite engine
- wren_pixel_draw  input  1  draw-bank write strobe
- sprite_done  input  1  engine line-complete flag
- sprite_start  output  1  one-cycle pulse: begin rendering next line
- pix_data  output  16  sprite pixel for hcount of the previous cycle
- pix_opaque  output  1  pix_data valid and non-transparent
- init_busy  output  1  buffers being cleared after reset
- overrun_cnt  output  8  saturating count of lines where the engine missed the swap

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, reset).
- Reset values:
  - bank_sel=0, state=INIT, clr_addr=0.
  - sprite_start=0, pix_data=0, pix_opaque=0, init_busy=1, overrun_cnt=0.
  - RAM contents are not reset; INIT clears them.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle writes TRANSPARENT to clr_addr in both banks, then clr_addr++.
  - At clr_addr==H_ACTIVE-1 the last write is done, the FSM moves to RUN and init_busy drops the next cycle (exactly H_ACTIVE cycles after reset release).
  - Engine writes are ignored, pix_opaque=0, and no sprite_start is issued.
- RUN, bank roles: display bank = bank_sel, draw bank = ~bank_sel.
- RUN, draw write:
  - When wren_pixel_draw=1, sprite_pixel_col<H_ACTIVE and sprite_pixel_data!=TRANSPARENT, store the data at that column in the draw bank.
  - Columns >=H_ACTIVE are dropped silently.
  - Later writes to the same column overwrite earlier ones (last-writer-wins).
- RUN, scanout:
  - Latency is 1 clk from hcount to pix_data/pix_opaque.
  - For hcount<H_ACTIVE: read the display bank at hcount. The next cycle drives pix_data = stored value and pix_opaque = (value!=TRANSPARENT), and writes TRANSPARENT to that address (read-then-clear).
  - For hcount>=H_ACTIVE: pix_data=0 and pix_opaque=0 on the next cycle.
- Swap:
  - Occurs on the cycle where hcount==H_TOTAL-1, in RUN.
  - bank_sel toggles at that edge.
  - sprite_start=1 for exactly the following cycle.
  - An engine write in the swap cycle lands in the pre-toggle draw bank.
- Overrun:
  - On a swap with sprite_done==0, overrun_cnt increments, saturating at 255.
  - The swap still happens; the partially drawn line is displayed.
- First swap after INIT also pulses sprite_start; the overrun check is skipped on that first swap.
- The display bank clear relies on a full active scan each line. Since hcount sweeps 0..H_ACTIVE-1 every line, including vblank, both banks stay clean.
- Reset asserted mid-line:
  - Returns to INIT immediately and all outputs go to reset values.
  - Any pending sprite_start is cancelled.
- RAM:
  - Per bank: one write port (draw or clear) plus one read port.
  - Read-during-write to the same address returns old data.
  - Arbitration: the INIT clear has priority. In RUN, each bank sees only its role's writer, so there is no conflict.

Test Plan:
- Reset released, hcount free-running → init_busy high for 640 cycles. Every pixel read in the following two lines gives pix_opaque=0, and no sprite_start occurs before the first hcount==799.
- Engine writes col 10 = 16'hF800 and col 639 = 16'h07E0 during line N, sprite_done=1 → in line N+1, pix_data=F800 with opaque one cycle after hcount=10, and 07E0 after hcount=639. Line N+2 at the same columns gives pix_opaque=0 (cleared).
- Writes at col 700 and col 20 with data 16'h0000 → no stored pixel; line N+1 shows pix_opaque=0 at col 20, and nothing is corrupted.
- sprite_done held 0 across 3 swaps → overrun_cnt=3 and banks still toggle. With sprite_done held 0 for 300 swaps, overrun_cnt saturates at 255.
- Write with wren asserted in the hcount==799 cycle, col 5 = 16'h001F → the pixel appears in the line displayed immediately after the swap, and sprite_start pulses exactly one cycle at hcount==0.
- Reset pulsed at hcount=300 of a line with opaque data → outputs go to 0 asynchronously, INIT reruns for 640 cycles, and the old sprite data never reappears.
